// File: rtl/data_serializer_pkg.sv
// rtl/data_serializer_pkg.sv - FunSel encodings, state enum and byte-selection helpers
package data_serializer_pkg;

  // Order/count select carried on FunSel
  typedef enum logic [1:0] {
    LSB4  = 2'b00,
    MSB4  = 2'b01,
    LSB2  = 2'b10,
    BYTE1 = 2'b11
  } funsel_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Number of bytes a word contributes for a given FunSel
  function automatic logic [2:0] byte_count(funsel_e fs);
    case (fs)
      LSB4, MSB4: byte_count = 3'd4;
      LSB2:       byte_count = 3'd2;
      default:    byte_count = 3'd1;
    endcase
  endfunction

  // Offset of the first byte emitted: only MSB-first starts at the top byte
  function automatic logic [1:0] first_offset(funsel_e fs);
    first_offset = (fs == MSB4) ? 2'd3 : 2'd0;
  endfunction

  // Byte of a word at a given offset (0 = bits 7:0)
  function automatic logic [7:0] pick_byte(logic [31:0] w, logic [1:0] off);
    case (off)
      2'd0:    pick_byte = w[7:0];
      2'd1:    pick_byte = w[15:8];
      2'd2:    pick_byte = w[23:16];
      default: pick_byte = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/data_serializer.sv
// rtl/data_serializer.sv - 32-bit word to 8-bit byte stream serializer with ready/valid handshake
module data_serializer
  import data_serializer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] I,
  input  logic [1:0]  FunSel,
  input  logic        Ready,
  output logic [7:0]  DOut,
  output logic        Valid,
  output logic [1:0]  Offset,
  output logic        Busy,
  output logic        Done
);

  state_e      state_q,  state_d;
  logic [31:0] word_q,   word_d;
  funsel_e     sel_q,    sel_d;
  logic [2:0]  cnt_q,    cnt_d;
  logic [7:0]  dout_q,   dout_d;
  logic [1:0]  offset_q, offset_d;
  logic        valid_q,  valid_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;

  // Next-state and registered-output computation; every output is decided one edge ahead
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    offset_d = offset_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        dout_d   = 8'h00;
        offset_d = 2'd0;
        if (Start) begin
          word_d   = I;
          sel_d    = funsel_e'(FunSel);
          cnt_d    = byte_count(sel_d);
          offset_d = first_offset(sel_d);
          dout_d   = pick_byte(I, offset_d);
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        // Valid is always high here, so Ready alone marks a transfer
        if (Ready) begin
          if (cnt_q == 3'd1) begin
            cnt_d    = 3'd0;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            dout_d   = 8'h00;
            offset_d = 2'd0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d    = cnt_q - 3'd1;
            offset_d = (sel_q == MSB4) ? (offset_q - 2'd1) : (offset_q + 2'd1);
            dout_d   = pick_byte(word_q, offset_d);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, capture and output registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= IDLE;
      word_q   <= 32'h0;
      sel_q    <= LSB4;
      cnt_q    <= 3'd0;
      dout_q   <= 8'h00;
      offset_q <= 2'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      offset_q <= offset_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign DOut   = dout_q;
  assign Valid  = valid_q;
  assign Offset = offset_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_data_serializer.sv
// tb/tb_data_serializer.sv - self-checking bench for data_serializer
module tb_data_serializer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] I = 32'h0;
  logic [1:0]  FunSel = 2'b00;
  logic        Ready = 1'b0;
  logic [7:0]  DOut;
  logic        Valid;
  logic [1:0]  Offset;
  logic        Busy;
  logic        Done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]      word;
    logic [1:0]       fs;
    int               n;
    logic [3:0][7:0]  bytes;
    logic [3:0][1:0]  offs;
    int               mode;
  } vec_t;

  vec_t vecs[6];

  data_serializer dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .I      (I),
    .FunSel (FunSel),
    .Ready  (Ready),
    .DOut   (DOut),
    .Valid  (Valid),
    .Offset (Offset),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"},  Valid,  0);
    check({tag, "_busy"},   Busy,   0);
    check({tag, "_dout"},   DOut,   0);
    check({tag, "_offset"}, Offset, 0);
  endtask

  // Reference: byte order from the offset sequence each FunSel implies
  task automatic model(input logic [31:0] w, input logic [1:0] fs,
                       output int n, output logic [3:0][7:0] eb, output logic [3:0][1:0] eo);
    int offs[$];
    case (fs)
      2'b00:   offs = '{0, 1, 2, 3};
      2'b01:   offs = '{3, 2, 1, 0};
      2'b10:   offs = '{0, 1};
      default: offs = '{0};
    endcase
    n  = offs.size();
    eb = '0;
    eo = '0;
    for (int k = 0; k < n; k++) begin
      eb[k] = 8'((w >> (8 * offs[k])) & 32'hFF);
      eo[k] = 2'(offs[k]);
    end
  endtask

  // Starts a word now (called just after an edge), streams it, ends sampling the Done cycle.
  // mode 0: Ready always high; 1: random Ready; 2: pattern 1,0,0,1,1,0,1
  task automatic run_word(input logic [31:0] w, input logic [1:0] fs, input int n,
                          input logic [3:0][7:0] eb, input logic [3:0][1:0] eo, input int mode);
    int k;
    int cyc;
    logic rdy;
    logic [6:0] pat;
    pat    = 7'b1011001;
    Start  = 1'b1;
    I      = w;
    FunSel = fs;
    @(posedge Clock); #1;
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 64) begin
      check("valid",    Valid,  1);
      check("busy",     Busy,   1);
      check("done_low", Done,   0);
      check("dout",     DOut,   eb[k]);
      check("offset",   Offset, eo[k]);
      Start  = 1'($urandom_range(0, 1));
      I      = $urandom;
      FunSel = 2'($urandom_range(0, 3));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc < 7) ? pat[cyc] : 1'b1;
      endcase
      Ready = rdy;
      @(posedge Clock); #1;
      if (rdy) k++;
      cyc++;
    end
    if (k < n) check("transfer_timeout", k, n);
    Start = 1'b0;
    Ready = 1'($urandom_range(0, 1));
    check("done_pulse", Done, 1);
    check_idle_outputs("after_last");
  endtask

  task automatic idle_cycles(input int c);
    for (int j = 0; j < c; j++) begin
      @(posedge Clock); #1;
      check("idle_done", Done, 0);
      check_idle_outputs("idle");
    end
  endtask

  initial begin
    int n;
    logic [3:0][7:0] eb;
    logic [3:0][1:0] eo;
    logic [31:0] w;
    logic [1:0] fs;

    vecs[0] = '{32'hA1B2C3D4, 2'b00, 4, 32'hA1B2C3D4, 8'hE4, 0};
    vecs[1] = '{32'hA1B2C3D4, 2'b01, 4, 32'hD4C3B2A1, 8'h1B, 2};
    vecs[2] = '{32'h0000BEEF, 2'b10, 2, 32'h0000BEEF, 8'h04, 0};
    vecs[3] = '{32'h0000007E, 2'b11, 1, 32'h0000007E, 8'h00, 0};
    vecs[4] = '{32'h11223344, 2'b00, 4, 32'h11223344, 8'hE4, 1};
    vecs[5] = '{32'h55667788, 2'b00, 4, 32'h55667788, 8'hE4, 0};

    // Reset state, with Start asserted to show reset wins
    Reset = 1'b0;
    Start = 1'b1;
    I     = 32'hDEADBEEF;
    Ready = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_done", Done, 0);
    check_idle_outputs("reset");

    // First Start lands on the first edge with Reset released; words back-to-back in Done cycles
    Reset = 1'b1;
    for (int v = 0; v < 6; v++)
      run_word(vecs[v].word, vecs[v].fs, vecs[v].n, vecs[v].bytes, vecs[v].offs, vecs[v].mode);
    idle_cycles(2);

    // Reset after two of four bytes: abort with no Done, then clean restart
    Start  = 1'b1;
    I      = 32'hA1B2C3D4;
    FunSel = 2'b00;
    @(posedge Clock); #1;
    Start = 1'b0;
    Ready = 1'b1;
    check("abort_b0", DOut, 8'hD4);
    @(posedge Clock); #1;
    check("abort_b1", DOut, 8'hC3);
    @(posedge Clock); #1;
    check("abort_b2", DOut, 8'hB2);
    check("abort_off2", Offset, 2);
    Reset = 1'b0;
    Start = 1'b1;
    @(posedge Clock); #1;
    check("abort_done", Done, 0);
    check_idle_outputs("abort");
    Reset = 1'b1;
    Start = 1'b0;
    Ready = 1'b0;
    @(posedge Clock); #1;
    check("abort_done2", Done, 0);
    check_idle_outputs("abort2");
    run_word(vecs[0].word, vecs[0].fs, vecs[0].n, vecs[0].bytes, vecs[0].offs, 0);

    // Randomized words against the reference model
    for (int r = 0; r < 150; r++) begin
      w  = $urandom;
      fs = 2'($urandom_range(0, 3));
      model(w, fs, n, eb, eo);
      run_word(w, fs, n, eb, eo, 1);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
